// File: rtl/thresholding_pe.sv
// Binary-search thresholding core: PE parallel lanes, C channels folded over
// CF = C/PE beats, N-stage pipeline with ready/valid backpressure.

module thresholding_lane #(
  parameter int N      = 4,
  parameter int M      = 16,
  parameter int CF     = 4,
  parameter int FW     = 2,
  parameter bit SIGNED = 1'b1,
  parameter int BIAS   = 0
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [M-1:0]         x,
  input  logic [N-1:0][FW-1:0] st_fold,
  input  logic                 we,
  input  logic [N-1:0]         w_stage,
  input  logic [FW-1:0]        w_fold,
  input  logic [N-1:1]         w_idx,
  input  logic [M-1:0]         w_dat,
  output logic [N-1:0]         y
);
  logic [N-1:1][M-1:0] x_pipe_d, x_pipe_q;

  always_comb begin
    x_pipe_d = x_pipe_q;
    if (en) x_pipe_d = {x_pipe_q[N-2:1], x};
  end

  always_ff @(posedge clk) x_pipe_q <= x_pipe_d;

  for (genvar s = 0; s < N; s++) begin : g_st
    localparam int D  = 1 << s;
    localparam int AW = (CF * D > 1) ? $clog2(CF * D) : 1;
    logic [M-1:0]  thr_mem [CF*D];
    logic [AW-1:0] ra, wa;
    logic [M-1:0]  xs, thr;
    logic          ge;
    logic [s:0]    res_d, res_q;

    // Entry per fold is the result prefix so far, MSB first.
    if (s == 0) begin : g_first
      assign xs    = x;
      assign ra    = AW'(st_fold[0]);
      assign res_d = ge;
    end else begin : g_next
      assign xs    = x_pipe_q[s];
      assign ra    = AW'(st_fold[s] * D + g_st[s-1].res_q);
      assign res_d = {g_st[s-1].res_q, ge};
    end

    assign thr = thr_mem[ra];
    assign ge  = SIGNED ? ($signed(thr) <= $signed(xs)) : (thr <= xs);
    assign wa  = AW'(w_fold * D + (w_idx >> (N - 1 - s)));

    always_ff @(posedge clk) begin
      if (we && w_stage[s]) thr_mem[wa] <= w_dat;
      if (en) res_q <= res_d;
    end
  end

  assign y = g_st[N-1].res_q + N'(BIAS);
endmodule

module thresholding_pe #(
  parameter int N      = 4,
  parameter int M      = 16,
  parameter int C      = 8,
  parameter int PE     = 2,
  parameter bit SIGNED = 1'b1,
  parameter int BIAS   = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        twe,
  input  logic [$clog2(C/PE)+$clog2(PE)+N-1:0]        twa,
  input  logic [M-1:0]                                twd,
  input  logic                                        ivld,
  output logic                                        irdy,
  input  logic [PE*M-1:0]                             idat,
  output logic                                        ovld,
  input  logic                                        ordy,
  output logic [((C/PE) > 1 ? $clog2(C/PE) : 1)-1:0]  ocnl,
  output logic [PE*N-1:0]                             odat
);
  localparam int CF  = C / PE;
  localparam int CFB = $clog2(CF);
  localparam int LWB = $clog2(PE);
  localparam int FW  = (CFB > 0) ? CFB : 1;
  localparam int LW  = (LWB > 0) ? LWB : 1;

  logic [N-1:0]  w_sfx, w_inc, w_low, w_stage;
  logic [FW-1:0] w_fold;
  logic [LW-1:0] w_lane;

  assign w_sfx = twa[N-1:0];
  if (LWB > 0) begin : g_wl
    assign w_lane = twa[N +: LWB];
  end else begin : g_wl0
    assign w_lane = '0;
  end
  if (CFB > 0) begin : g_wf
    assign w_fold = twa[N+LWB +: CFB];
  end else begin : g_wf0
    assign w_fold = '0;
  end

  // Stage = N-1 - lowest set bit of (suffix+1); all-ones suffix selects none.
  always_comb begin
    w_inc   = w_sfx + N'(1);
    w_low   = w_inc & (~w_inc + N'(1));
    w_stage = '0;
    for (int s = 0; s < N; s++) w_stage[s] = w_low[N-1-s];
  end

  logic                 en, acc;
  logic [N:1]           vld_pipe_d, vld_pipe_q;
  logic [FW-1:0]        cnl_d, cnl_q;
  logic [N:1][FW-1:0]   fold_pipe_d, fold_pipe_q;
  logic [N-1:0][FW-1:0] st_fold;

  assign st_fold = {fold_pipe_q[N-1:1], cnl_q};

  always_comb begin
    en          = !vld_pipe_q[N] || ordy;
    acc         = ivld && en;
    vld_pipe_d  = vld_pipe_q;
    fold_pipe_d = fold_pipe_q;
    cnl_d       = cnl_q;
    if (en) begin
      vld_pipe_d  = {vld_pipe_q[N-1:1], acc};
      fold_pipe_d = {fold_pipe_q[N-1:1], cnl_q};
    end
    if (acc) cnl_d = (cnl_q == FW'(CF - 1)) ? '0 : cnl_q + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      fold_pipe_q <= '0;
      cnl_q       <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      fold_pipe_q <= fold_pipe_d;
      cnl_q       <= cnl_d;
    end
  end

  assign irdy = en;
  assign ovld = vld_pipe_q[N];
  assign ocnl = fold_pipe_q[N];

  for (genvar p = 0; p < PE; p++) begin : g_lane
    thresholding_lane #(
      .N(N), .M(M), .CF(CF), .FW(FW), .SIGNED(SIGNED), .BIAS(BIAS)
    ) u_lane (
      .clk     (clk),
      .en      (en),
      .x       (idat[p*M +: M]),
      .st_fold (st_fold),
      .we      (twe && (w_lane == LW'(p))),
      .w_stage (w_stage),
      .w_fold  (w_fold),
      .w_idx   (w_sfx[N-1:1]),
      .w_dat   (twd),
      .y       (odat[p*N +: N])
    );
  end
endmodule

// File: tb/tb_thresholding_pe.sv
// Directed bench for thresholding_pe: five instances cover the folded
// signed core, the unfolded core, unsigned compare and a negative bias.

module tb_thresholding_pe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // u_a: N=4 M=16 C=1 PE=1 signed
  logic a_twe, a_ivld, a_irdy, a_ovld, a_ordy;
  logic [3:0] a_twa, a_odat;
  logic [15:0] a_twd, a_idat;
  logic [0:0] a_ocnl;

  thresholding_pe #(.N(4), .M(16), .C(1), .PE(1), .SIGNED(1'b1), .BIAS(0)) u_a (
    .clk(clk), .rst(rst), .twe(a_twe), .twa(a_twa), .twd(a_twd),
    .ivld(a_ivld), .irdy(a_irdy), .idat(a_idat),
    .ovld(a_ovld), .ordy(a_ordy), .ocnl(a_ocnl), .odat(a_odat));

  // u_b: N=4 M=16 C=8 PE=2 signed
  logic b_twe, b_ivld, b_irdy, b_ovld, b_ordy;
  logic [6:0] b_twa;
  logic [15:0] b_twd;
  logic [31:0] b_idat;
  logic [1:0] b_ocnl;
  logic [7:0] b_odat;

  thresholding_pe #(.N(4), .M(16), .C(8), .PE(2), .SIGNED(1'b1), .BIAS(0)) u_b (
    .clk(clk), .rst(rst), .twe(b_twe), .twa(b_twa), .twd(b_twd),
    .ivld(b_ivld), .irdy(b_irdy), .idat(b_idat),
    .ovld(b_ovld), .ordy(b_ordy), .ocnl(b_ocnl), .odat(b_odat));

  // u_c unsigned, u_d signed, u_e signed with BIAS=-8; shared M=8 input bus
  logic c_twe, c_ivld, c_ordy;
  logic [3:0] c_twa;
  logic [7:0] c_twd, c_idat;
  logic c_irdy, d_irdy, e_irdy, c_ovld, d_ovld, e_ovld;
  logic [0:0] c_ocnl, d_ocnl, e_ocnl;
  logic [3:0] c_odat, d_odat, e_odat;

  thresholding_pe #(.N(4), .M(8), .C(1), .PE(1), .SIGNED(1'b0), .BIAS(0)) u_c (
    .clk(clk), .rst(rst), .twe(c_twe), .twa(c_twa), .twd(c_twd),
    .ivld(c_ivld), .irdy(c_irdy), .idat(c_idat),
    .ovld(c_ovld), .ordy(c_ordy), .ocnl(c_ocnl), .odat(c_odat));
  thresholding_pe #(.N(4), .M(8), .C(1), .PE(1), .SIGNED(1'b1), .BIAS(0)) u_d (
    .clk(clk), .rst(rst), .twe(c_twe), .twa(c_twa), .twd(c_twd),
    .ivld(c_ivld), .irdy(d_irdy), .idat(c_idat),
    .ovld(d_ovld), .ordy(c_ordy), .ocnl(d_ocnl), .odat(d_odat));
  thresholding_pe #(.N(4), .M(8), .C(1), .PE(1), .SIGNED(1'b1), .BIAS(-8)) u_e (
    .clk(clk), .rst(rst), .twe(c_twe), .twa(c_twa), .twd(c_twd),
    .ivld(c_ivld), .irdy(e_irdy), .idat(c_idat),
    .ovld(e_ovld), .ordy(c_ordy), .ocnl(e_ocnl), .odat(e_odat));

  typedef struct { logic [3:0] dat; int cyc; } a_exp_t;
  typedef struct { logic [7:0] dat; logic [1:0] cnl; } b_exp_t;
  a_exp_t aq[$];
  b_exp_t bq[$];
  int a_cyc = 0;
  int tb_fold = 0;
  bit b_hold = 1'b0;
  logic [7:0] b_hdat;
  logic [1:0] b_hcnl;
  int thr_b [4][2][15];
  int offs [8] = '{3, -20, 50, 3, 7, 0, 29, 3};
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  function automatic logic [3:0] b_model(int f, int p, logic [15:0] x);
    int c = 0;
    for (int i = 0; i < 15; i++) if (thr_b[f][p][i] <= int'($signed(x))) c++;
    return c[3:0];
  endfunction

  task automatic a_wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); a_twe = 1'b1; a_twa = a; a_twd = d;
  endtask

  task automatic b_wr(input int f, input int p, input int i, input int v);
    @(negedge clk); b_twe = 1'b1; b_twa = {2'(f), 1'(p), 4'(i)}; b_twd = 16'(v);
    thr_b[f][p][i] = v;
  endtask

  task automatic c_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); c_twe = 1'b1; c_twa = a; c_twd = d;
  endtask

  task automatic a_cycle(input bit v, input logic [15:0] x, input logic [3:0] e);
    a_exp_t q;
    @(negedge clk); a_ivld = v; a_idat = x; a_ordy = 1'b1;
    #4;
    if (a_ovld && a_ordy) begin
      if (aq.size() == 0) chk("a_stale", a_ovld, 0);
      else begin
        q = aq.pop_front();
        chk("a_odat", a_odat, q.dat);
        chk("a_lat", a_cyc - q.cyc, 4);
        chk("a_ocnl", a_ocnl, 0);
      end
    end
    if (a_ivld && a_irdy) aq.push_back('{dat: e, cyc: a_cyc});
    a_cyc++;
  endtask

  task automatic b_cycle(input bit v, input logic [31:0] x, input bit r, input bit we,
                         input logic [6:0] wa, input logic [15:0] wd, output bit acc);
    b_exp_t q;
    @(negedge clk);
    b_ivld = v; b_idat = x; b_ordy = r; b_twe = we; b_twa = wa; b_twd = wd;
    #4;
    if (b_hold) begin
      chk("b_hold_vld", b_ovld, 1);
      chk("b_hold_dat", b_odat, b_hdat);
      chk("b_hold_cnl", b_ocnl, b_hcnl);
    end
    if (b_ovld && b_ordy) begin
      if (bq.size() == 0) chk("b_stale", b_ovld, 0);
      else begin
        q = bq.pop_front();
        chk("b_odat", b_odat, q.dat);
        chk("b_ocnl", b_ocnl, q.cnl);
      end
    end
    b_hold = b_ovld && !b_ordy;
    if (b_hold) begin
      b_hdat = b_odat; b_hcnl = b_ocnl;
      chk("b_stall_irdy", b_irdy, 0);
    end
    acc = b_ivld && b_irdy;
    if (acc) begin
      bq.push_back('{dat: {b_model(tb_fold, 1, x[31:16]), b_model(tb_fold, 0, x[15:0])},
                     cnl: 2'(tb_fold)});
      tb_fold = (tb_fold + 1) % 4;
    end
  endtask

  task automatic b_stream(input int nb, input bit bp);
    int sent = 0;
    int k = 0;
    bit acc;
    logic [15:0] l0, l1;
    while (sent < nb && k < 200) begin
      l0 = 16'(200 * tb_fold + offs[sent % 8]);
      l1 = 16'(200 * tb_fold + 100 + offs[sent % 8]);
      b_cycle(1'b1, {l1, l0}, bp ? pat[k % 4] : 1'b1, 1'b0, '0, '0, acc);
      if (acc) sent++;
      k++;
    end
    chk("b_sent", sent, nb);
  endtask

  task automatic b_drain();
    int k = 0;
    bit acc;
    while (bq.size() > 0 && k < 40) begin
      b_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, acc);
      k++;
    end
    chk("b_drain", bq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_ivld = 1'b0; b_ivld = 1'b0; c_ivld = 1'b0; b_twe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_b_ovld", b_ovld, 0);
    chk("rst_b_irdy", b_irdy, 1);
    chk("rst_b_ocnl", b_ocnl, 0);
    chk("rst_a_ovld", a_ovld, 0);
    bq.delete(); tb_fold = 0; b_hold = 1'b0;
  endtask

  task automatic c_beat(input string tag, input logic [7:0] x,
                        input logic [3:0] ec, input logic [3:0] ed, input logic [3:0] ee);
    int k = 0;
    @(negedge clk); c_ivld = 1'b1; c_idat = x; c_ordy = 1'b1;
    @(negedge clk); c_ivld = 1'b0;
    while (!c_ovld && k < 10) begin @(negedge clk); k++; end
    chk({tag, "_vld"}, c_ovld, 1);
    chk({tag, "_uns"}, c_odat, ec);
    chk({tag, "_sgn"}, d_odat, ed);
    chk({tag, "_bias"}, e_odat, ee);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit acc;
    // Hand-derived: thresholds T_i = i-7 (-7..7)
    logic [15:0] a_x [6] = '{-16'sd100, -16'sd8, -16'sd7, 16'sd0, 16'sd7, 16'sd8};
    logic [3:0]  a_e [6] = '{4'd0, 4'd0, 4'd1, 4'd8, 4'd15, 4'd15};

    rst = 1'b1;
    {a_twe, a_ivld, a_ordy, b_twe, b_ivld, b_ordy, c_twe, c_ivld, c_ordy} = '0;
    a_twa = '0; a_twd = '0; a_idat = '0;
    b_twa = '0; b_twd = '0; b_idat = '0;
    c_twa = '0; c_twd = '0; c_idat = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_a_ovld", a_ovld, 0);
    chk("rst_a_irdy", a_irdy, 1);
    chk("rst_a_ocnl", a_ocnl, 0);
    chk("rst_b_ovld", b_ovld, 0);
    chk("rst_b_irdy", b_irdy, 1);
    chk("rst_b_ocnl", b_ocnl, 0);
    chk("rst_c_ovld", c_ovld, 0);

    for (int i = 0; i < 15; i++) a_wr(4'(i), 16'(i - 7));
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 2; p++)
        for (int i = 0; i < 15; i++) b_wr(f, p, i, 100 * (2 * f + p) + 2 * i);
    for (int i = 0; i < 15; i++) c_wr(4'(i), 8'(i + 1));
    @(negedge clk); a_twe = 1'b0; b_twe = 1'b0; c_twe = 1'b0;

    // Unfolded core, back-to-back with fixed latency
    for (int k = 0; k < 6; k++) a_cycle(1'b1, a_x[k], a_e[k]);
    for (int k = 0; k < 12 && aq.size() > 0; k++) a_cycle(1'b0, '0, '0);
    chk("a_drain", aq.size(), 0);

    // Folded stream, then continuous input under 1,0,0,1 ordy
    b_stream(8, 1'b0);
    b_drain();
    b_stream(12, 1'b1);
    b_drain();

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      b_cycle(1'b1, {16'd103, 16'd3}, 1'b1, 1'b0, '0, '0, acc);
      chk("b_inflight_acc", acc, 1);
    end
    do_reset();
    b_stream(5, 1'b0);
    b_drain();

    // Stage-0 threshold of fold 0 lane 0 rewritten 5 -> 50 as a fold-0 beat reads it
    do_reset();
    for (int i = 0; i < 15; i++) b_wr(0, 0, i, (i <= 7) ? i - 2 : 60 + i);
    b_cycle(1'b1, {16'd103, 16'd10}, 1'b1, 1'b1, 7'd7, 16'd50, acc);
    chk("b_wr_acc", acc, 1);
    thr_b[0][0][7] = 50;
    b_stream(3, 1'b0);
    b_cycle(1'b1, {16'd103, 16'd10}, 1'b1, 1'b0, '0, '0, acc);
    chk("b_wr_acc2", acc, 1);
    b_drain();

    // Thresholds 1..15 on the 8-bit instances
    c_beat("c_f0", 8'hF0, 4'd15, 4'd0, 4'h8);
    c_beat("c_00", 8'h00, 4'd0, 4'd0, 4'h8);
    c_beat("c_08", 8'h08, 4'd8, 4'd8, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
